// File: rtl/clock_pkg.sv
// Shared time-of-day definitions: BCD digit fields of the 32-bit time word,
// digit moduli and the 24-hour limit. Also imported by the alarm/display controller.
package clock_pkg;

   localparam int unsigned HT_MSB = 31;
   localparam int unsigned HT_LSB = 28;
   localparam int unsigned HU_MSB = 27;
   localparam int unsigned HU_LSB = 24;
   localparam int unsigned MT_MSB = 23;
   localparam int unsigned MT_LSB = 20;
   localparam int unsigned MU_MSB = 19;
   localparam int unsigned MU_LSB = 16;
   localparam int unsigned ST_MSB = 15;
   localparam int unsigned ST_LSB = 12;
   localparam int unsigned SU_MSB = 11;
   localparam int unsigned SU_LSB = 8;
   localparam int unsigned CT_MSB = 7;
   localparam int unsigned CT_LSB = 4;
   localparam int unsigned CU_MSB = 3;
   localparam int unsigned CU_LSB = 0;

   localparam int unsigned MOD_DEC = 10;
   localparam int unsigned MOD_SEX = 6;
   localparam logic [7:0]  HOUR_LIMIT = 8'h23;

   typedef logic [3:0]  bcd_t;
   typedef logic [31:0] time_word_t;

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit counting 0..MOD-1; clr has priority over en.
// carry flags the enabled cycle in which the digit rolls over.
module bcd_digit
   import clock_pkg::*;
#(
   parameter int unsigned MOD = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output bcd_t q,
   output logic carry
);

   localparam bcd_t LAST = 4'(MOD - 1);

   bcd_t q_q;
   bcd_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = (q_q == LAST) ? '0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = en && (q_q == LAST);

endmodule

// File: rtl/time_counter.sv
// Free-running BCD time-of-day counter with 100 Hz prescaler, 24-hour wrap
// and a set mode that freezes counting and steps hours/minutes by pulses.
module time_counter
   import clock_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       time_set,
   input  logic       inc_hour,
   input  logic       inc_min,
   output time_word_t current_time,
   output logic       sec_tick,
   output logic       day_wrap
);

   localparam int unsigned DIV   = CLK_HZ / 100;
   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_d;
   logic             tick100_c;

   bcd_t cu, ct, su, st, mu, mt, hu, ht;
   logic cu_cy, ct_cy, su_cy, st_cy, mu_cy, mt_cy, hu_cy;
   logic ht_carry_unused;
   logic mu_en_c, hu_en_c, hour_wrap_c;

   logic sec_tick_q, day_wrap_q;
   time_word_t time_c;

   assign tick100_c = (pre_q == PRE_LAST) && !time_set;

   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      if (time_set || (pre_q == PRE_LAST)) begin
         pre_d = '0;
      end
   end

   // Set-mode steps join the count chain; minute rollover in set mode never reaches hours.
   assign mu_en_c     = st_cy || (time_set && inc_min);
   assign hu_en_c     = time_set ? inc_hour : mt_cy;
   assign hour_wrap_c = hu_en_c && ({ht, hu} == HOUR_LIMIT);

   bcd_digit #(.MOD(MOD_DEC)) u_cu (.clk(clk), .reset(reset), .en(tick100_c), .clr(time_set),
                                    .q(cu), .carry(cu_cy));
   bcd_digit #(.MOD(MOD_DEC)) u_ct (.clk(clk), .reset(reset), .en(cu_cy), .clr(time_set),
                                    .q(ct), .carry(ct_cy));
   bcd_digit #(.MOD(MOD_DEC)) u_su (.clk(clk), .reset(reset), .en(ct_cy), .clr(time_set),
                                    .q(su), .carry(su_cy));
   bcd_digit #(.MOD(MOD_SEX)) u_st (.clk(clk), .reset(reset), .en(su_cy), .clr(time_set),
                                    .q(st), .carry(st_cy));
   bcd_digit #(.MOD(MOD_DEC)) u_mu (.clk(clk), .reset(reset), .en(mu_en_c), .clr(1'b0),
                                    .q(mu), .carry(mu_cy));
   bcd_digit #(.MOD(MOD_SEX)) u_mt (.clk(clk), .reset(reset), .en(mu_cy), .clr(1'b0),
                                    .q(mt), .carry(mt_cy));
   // Hours pair: 23 detection clears both digits before Hu could reach 4.
   bcd_digit #(.MOD(MOD_DEC)) u_hu (.clk(clk), .reset(reset), .en(hu_en_c), .clr(hour_wrap_c),
                                    .q(hu), .carry(hu_cy));
   bcd_digit #(.MOD(MOD_DEC)) u_ht (.clk(clk), .reset(reset), .en(hu_cy), .clr(hour_wrap_c),
                                    .q(ht), .carry(ht_carry_unused));

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q      <= '0;
         sec_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         sec_tick_q <= ct_cy;
         day_wrap_q <= hour_wrap_c && !time_set;
      end
   end

   always_comb begin
      time_c = '0;
      time_c[HT_MSB:HT_LSB] = ht;
      time_c[HU_MSB:HU_LSB] = hu;
      time_c[MT_MSB:MT_LSB] = mt;
      time_c[MU_MSB:MU_LSB] = mu;
      time_c[ST_MSB:ST_LSB] = st;
      time_c[SU_MSB:SU_LSB] = su;
      time_c[CT_MSB:CT_LSB] = ct;
      time_c[CU_MSB:CU_LSB] = cu;
   end

   assign current_time = time_c;
   assign sec_tick     = sec_tick_q;
   assign day_wrap     = day_wrap_q;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter at CLK_HZ=400 (DIV=4); inputs driven and
// outputs sampled on the falling edge.
module tb_time_counter;

   localparam int unsigned DIV = 4;

   logic        clk;
   logic        reset;
   logic        time_set;
   logic        inc_hour;
   logic        inc_min;
   logic [31:0] current_time;
   logic        sec_tick;
   logic        day_wrap;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic        set_glitch = 1'b0;

   time_counter #(.CLK_HZ(400)) dut (
      .clk          (clk),
      .reset        (reset),
      .time_set     (time_set),
      .inc_hour     (inc_hour),
      .inc_min      (inc_min),
      .current_time (current_time),
      .sec_tick     (sec_tick),
      .day_wrap     (day_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // One set-mode button pulse followed by an idle cycle; records any stray pulse outputs.
   task automatic pulse(input logic h, input logic m);
      inc_hour = h;
      inc_min  = m;
      @(negedge clk);
      set_glitch = set_glitch | sec_tick | day_wrap;
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      @(negedge clk);
      set_glitch = set_glitch | sec_tick | day_wrap;
   endtask

   initial begin
      reset    = 1'b1;
      time_set = 1'b0;
      inc_hour = 1'b0;
      inc_min  = 1'b0;

      // Reset and first increments
      step(3);
      chk("rst_time", current_time, 32'h0000_0000);
      chk("rst_sec_tick", {31'd0, sec_tick}, 32'd0);
      chk("rst_day_wrap", {31'd0, day_wrap}, 32'd0);
      reset = 1'b0;
      step(DIV - 1);
      chk("pre_first", current_time, 32'h0000_0000);
      step(1);
      chk("first_inc", current_time, 32'h0000_0001);
      step(DIV);
      chk("second_inc", current_time, 32'h0000_0002);

      // Hundredths -> seconds carry, then seconds -> minutes carry
      step(DIV * 97);
      chk("at_0099", current_time, 32'h0000_0099);
      step(DIV);
      chk("sec_carry", current_time, 32'h0000_0100);
      chk("sec_tick_hi", {31'd0, sec_tick}, 32'd1);
      step(1);
      chk("sec_tick_lo", {31'd0, sec_tick}, 32'd0);
      step(DIV * 5899 - 1);
      chk("at_5999", current_time, 32'h0000_5999);
      step(DIV);
      chk("min_carry", current_time, 32'h0001_0000);

      // Set mode stepping
      reset = 1'b1;
      step(1);
      chk("rst_again", current_time, 32'h0000_0000);
      reset    = 1'b0;
      time_set = 1'b1;
      pulse(1'b0, 1'b1);
      chk("set_min1", current_time, 32'h0001_0000);
      for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
      chk("set_min_wrap", current_time, 32'h0000_0000);
      for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
      chk("set_hour23", current_time, 32'h2300_0000);
      pulse(1'b1, 1'b0);
      chk("set_hour_wrap", current_time, 32'h0000_0000);
      for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
      chk("set_2359", current_time, 32'h2359_0000);
      pulse(1'b1, 1'b1);
      chk("set_both_wrap", current_time, 32'h0000_0000);
      for (int i = 0; i < 23; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1);
      chk("set_no_pulses", {31'd0, set_glitch}, 32'd0);

      // Pulses ignored outside set mode; counting resumes from pre=0
      time_set = 1'b0;
      inc_hour = 1'b1;
      inc_min  = 1'b1;
      step(1);
      inc_hour = 1'b0;
      inc_min  = 1'b0;
      chk("ignored_pulses", current_time, 32'h2359_0000);
      step(DIV * 5999 - 1);
      chk("at_2359_5999", current_time, 32'h2359_5999);
      step(DIV);
      chk("day_wrap_time", current_time, 32'h0000_0000);
      chk("day_wrap_hi", {31'd0, day_wrap}, 32'd1);
      chk("day_sec_tick_hi", {31'd0, sec_tick}, 32'd1);
      step(1);
      chk("day_wrap_lo", {31'd0, day_wrap}, 32'd0);
      chk("day_sec_tick_lo", {31'd0, sec_tick}, 32'd0);

      // Reset mid-count at 12:34:56.78
      time_set = 1'b1;
      for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1);
      time_set = 1'b0;
      step(DIV * 5678);
      chk("at_1234_5678", current_time, 32'h1234_5678);
      reset = 1'b1;
      step(1);
      chk("mid_rst_time", current_time, 32'h0000_0000);
      chk("mid_rst_pulses", {30'd0, sec_tick, day_wrap}, 32'd0);
      reset = 1'b0;
      step(DIV - 1);
      chk("mid_rst_hold", current_time, 32'h0000_0000);
      step(1);
      chk("mid_rst_first", current_time, 32'h0000_0001);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
